hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised successor of the ID-stage stalling unit for the RV32IF pipeline. Combines the
//  single-cycle load-use check with a slot-based scoreboard for multi-cycle ops (FDIV/FSQRT/FMA,
//  MUL/DIV) writing the integer or FP register file. Asserts stall to hold IF/ID and bubble ID/EX.
//  Also keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_AW     5   register address width (rs/rd fields)
//  NUM_SLOTS  4   max in-flight multi-cycle ops tracked (>=1)
//  LAT_W      5   width of latency field/slot countdown; usable latency 1..2^LAT_W-1
//  PERF_W     32  width of stall-cycle counter
// PORTS
//  clk           in   1        pipeline clock, all state on rising edge
//  rst           in   1        asynchronous active-high reset
//  id_valid      in   1        valid instruction in IF/ID
//  id_rs1/2/3    in   REG_AW   source addresses (rs3 used only by R4-type FMA)
//  id_rs1/2/3_en in   1        source actually read (from decoder)
//  id_rs1/2/3_fp in   1        source is in FP file (1) or integer file (0)
//  id_rd         in   REG_AW   destination of ID instruction
//  id_rd_fp      in   1        destination file select
//  id_long_op    in   1        ID instruction is multi-cycle, needs a slot
//  id_lat        in   LAT_W    result latency in cycles of that op
//  ex_mem_read   in   1        instruction in ID/EX is a load (LW/FLW)
//  ex_rd         in   REG_AW   ID/EX destination
//  ex_rd_fp      in   1        ID/EX destination file select
//  flush         in   1        branch/jump redirect: kill ID instruction
//  stall         out  1        hold PC and IF/ID, insert bubble into ID/EX
//  stall_cause   out  2        0 none, 1 load-use, 2 scoreboard RAW/WAW, 3 slots full
//  sb_busy       out  NUM_SLOTS  per-slot valid bits
//  stall_cycles  out  PERF_W   saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset: all slot valid/rd/fp/cnt = 0, stall_cycles = 0; stall = 0, stall_cause = 0, sb_busy = 0.
//  Operand match: addresses equal AND file flags equal AND source enabled. Integer x0 never
//   matches; FP f0 is a real register and does match.
//  Load-use (combinational): id_valid & ex_mem_read & match(any source, ex_rd/ex_rd_fp).
//  Scoreboard RAW: id_valid & any valid slot matches any enabled source.
//  Scoreboard WAW: id_valid & id_long_op & valid slot with same rd/fp (forces in-order writeback);
//   integer rd=x0 exempt.
//  Full: id_valid & id_long_op & all NUM_SLOTS valid.
//  stall = OR of the three; stall_cause priority load-use > RAW/WAW > full. flush forces stall=0
//   and stall_cause=0 in the same cycle (killed instruction must not hold the pipe).
//  Issue = id_valid & id_long_op & !stall & !flush: on that edge lowest-index free slot loads
//   valid=1, rd, fp, cnt=id_lat (id_lat=0 treated as 1).
//  Countdown: each edge every valid slot with cnt>1 decrements; slot with cnt==1 clears valid
//   (result written back that cycle; RF write-through covers same-cycle read). Slot freed and
//   new issue on the same edge: freed slot usable next cycle only (allocation uses pre-edge valid).
//  Scoreboard is not cleared by flush: issued ops always complete. Async rst mid-operation drops
//   all slots immediately.
//  stall_cycles increments on each edge with stall=1; holds at all-ones.
//  All outputs except stall_cycles and sb_busy are combinational from inputs + slot state.
// TESTING
//  LW x5 in EX (ex_mem_read=1,ex_rd=5), ADD rs1=x5 in ID -> stall=1, cause=1 for 1 cycle; rd=x0 -> stall=0.
//  FLW f0 in EX, FADD rs2=f0 fp -> stall=1; same with integer rs2=x0 -> stall=0; int x3 vs fp f3 -> 0.
//  Issue FDIV f4 id_lat=3, next FADD reads f4 -> stall for 2 cycles cause=2, releases the 3rd cycle.
//  Issue 4 long ops lat=20 to distinct rd, 5th long op -> stall cause=3 until first slot expires.
//  Long op to f7 pending, second long op to f7 -> WAW stall; flush same cycle -> stall=0, no alloc.
//  rst asserted mid-countdown -> sb_busy=0, stall=0 immediately; stall_cycles saturates at 2^PERF_W-1.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: load-use check plus slot scoreboard for multi-cycle ops.
// Drives stall/bubble and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SLOTS = 4,
  parameter int LAT_W     = 5,
  parameter int PERF_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic [REG_AW-1:0]    id_rs3,
  input  logic                 id_rs1_en,
  input  logic                 id_rs2_en,
  input  logic                 id_rs3_en,
  input  logic                 id_rs1_fp,
  input  logic                 id_rs2_fp,
  input  logic                 id_rs3_fp,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 id_rd_fp,
  input  logic                 id_long_op,
  input  logic [LAT_W-1:0]     id_lat,
  input  logic                 ex_mem_read,
  input  logic [REG_AW-1:0]    ex_rd,
  input  logic                 ex_rd_fp,
  input  logic                 flush,
  output logic                 stall,
  output logic [1:0]           stall_cause,
  output logic [NUM_SLOTS-1:0] sb_busy,
  output logic [PERF_W-1:0]    stall_cycles
);

  logic [NUM_SLOTS-1:0] valid;
  logic [NUM_SLOTS-1:0] fp_q;
  logic [REG_AW-1:0]    rd_q  [NUM_SLOTS];
  logic [LAT_W-1:0]     cnt_q [NUM_SLOTS];

  logic                 load_use;
  logic                 raw;
  logic                 waw;
  logic                 full;
  logic                 issue;
  logic [NUM_SLOTS-1:0] alloc_oh;
  logic [LAT_W-1:0]     lat_eff;

  function automatic logic hit(
    input logic [REG_AW-1:0] a,
    input logic              af,
    input logic              en,
    input logic [REG_AW-1:0] b,
    input logic              bf
  );
    return en && (a == b) && (af == bf) && (af || (a != '0));
  endfunction

  function automatic logic src_hit(
    input logic [REG_AW-1:0] b,
    input logic              bf,
    input logic [REG_AW-1:0] r1,
    input logic              f1,
    input logic              e1,
    input logic [REG_AW-1:0] r2,
    input logic              f2,
    input logic              e2,
    input logic [REG_AW-1:0] r3,
    input logic              f3,
    input logic              e3
  );
    return hit(r1, f1, e1, b, bf) ||
           hit(r2, f2, e2, b, bf) ||
           hit(r3, f3, e3, b, bf);
  endfunction

  always_comb begin
    load_use = id_valid && ex_mem_read &&
               src_hit(ex_rd, ex_rd_fp,
                       id_rs1, id_rs1_fp, id_rs1_en,
                       id_rs2, id_rs2_fp, id_rs2_en,
                       id_rs3, id_rs3_fp, id_rs3_en);
    raw = 1'b0;
    waw = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // cnt==1 writes back this cycle; RF write-through covers the read
      if (valid[i] && cnt_q[i] != LAT_W'(1) &&
          src_hit(rd_q[i], fp_q[i],
                  id_rs1, id_rs1_fp, id_rs1_en,
                  id_rs2, id_rs2_fp, id_rs2_en,
                  id_rs3, id_rs3_fp, id_rs3_en))
        raw = 1'b1;
      if (valid[i] && rd_q[i] == id_rd && fp_q[i] == id_rd_fp &&
          (id_rd_fp || id_rd != '0))
        waw = 1'b1;
    end
    raw  = raw && id_valid;
    waw  = waw && id_valid && id_long_op;
    full = id_valid && id_long_op && (&valid);
  end

  always_comb begin
    stall       = 1'b0;
    stall_cause = 2'd0;
    if (!flush) begin
      if (load_use) begin
        stall       = 1'b1;
        stall_cause = 2'd1;
      end else if (raw || waw) begin
        stall       = 1'b1;
        stall_cause = 2'd2;
      end else if (full) begin
        stall       = 1'b1;
        stall_cause = 2'd3;
      end
    end
  end

  assign issue    = id_valid && id_long_op && !stall && !flush;
  assign alloc_oh = ~valid & (valid + NUM_SLOTS'(1));
  assign lat_eff  = (id_lat == '0) ? LAT_W'(1) : id_lat;
  assign sb_busy  = valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid        <= '0;
      fp_q         <= '0;
      stall_cycles <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (valid[i]) begin
          if (cnt_q[i] > LAT_W'(1))
            cnt_q[i] <= cnt_q[i] - LAT_W'(1);
          else
            valid[i] <= 1'b0;
        end else if (issue && alloc_oh[i]) begin
          valid[i] <= 1'b1;
          rd_q[i]  <= id_rd;
          fp_q[i]  <= id_rd_fp;
          cnt_q[i] <= lat_eff;
        end
      end
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus random traffic
// against a completion-time model of the in-flight ops.
module tb_hazard_scoreboard_unit;
  localparam int AW   = 5;
  localparam int NS   = 4;
  localparam int LW   = 5;
  localparam int PW   = 6;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rs3;
  logic          id_rs1_en, id_rs2_en, id_rs3_en;
  logic          id_rs1_fp, id_rs2_fp, id_rs3_fp;
  logic [AW-1:0] id_rd;
  logic          id_rd_fp;
  logic          id_long_op;
  logic [LW-1:0] id_lat;
  logic          ex_mem_read;
  logic [AW-1:0] ex_rd;
  logic          ex_rd_fp;
  logic          flush;
  logic          stall;
  logic [1:0]    stall_cause;
  logic [NS-1:0] sb_busy;
  logic [PW-1:0] stall_cycles;

  int vectors = 0;
  int errs    = 0;

  // model: each slot holds the cycle index at which it becomes free
  int            done_t [NS];
  logic [AW-1:0] m_rd   [NS];
  bit            m_fp   [NS];
  int            now;
  int            m_perf;
  bit            e_stall;
  logic [1:0]    e_cause;
  bit            e_issue;
  logic [NS-1:0] e_busy;

  hazard_scoreboard_unit #(
    .REG_AW(AW), .NUM_SLOTS(NS), .LAT_W(LW), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rs3_en(id_rs3_en),
    .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp), .id_rs3_fp(id_rs3_fp),
    .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_long_op(id_long_op),
    .id_lat(id_lat), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_rd_fp(ex_rd_fp), .flush(flush), .stall(stall),
    .stall_cause(stall_cause), .sb_busy(sb_busy),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit reads(input logic [AW-1:0] a, input bit af,
                               input bit en, input logic [AW-1:0] r,
                               input bit rf);
    return en && a == r && af == rf && (af || a != 0);
  endfunction

  function automatic bit any_src(input logic [AW-1:0] r, input bit rf);
    return reads(id_rs1, id_rs1_fp, id_rs1_en, r, rf) ||
           reads(id_rs2, id_rs2_fp, id_rs2_en, r, rf) ||
           reads(id_rs3, id_rs3_fp, id_rs3_en, r, rf);
  endfunction

  function automatic void model_eval();
    bit lu, raw, waw, full;
    int nbusy;
    lu = id_valid && ex_mem_read && any_src(ex_rd, ex_rd_fp);
    raw = 0; waw = 0; nbusy = 0;
    for (int i = 0; i < NS; i++) begin
      e_busy[i] = (now < done_t[i]);
      if (now < done_t[i]) begin
        nbusy++;
        if (now < done_t[i] - 1 && any_src(m_rd[i], m_fp[i])) raw = 1;
        if (m_rd[i] == id_rd && m_fp[i] == id_rd_fp &&
            (id_rd_fp || id_rd != 0)) waw = 1;
      end
    end
    raw  = raw && id_valid;
    waw  = waw && id_valid && id_long_op;
    full = id_valid && id_long_op && nbusy == NS;
    if (flush)          e_cause = 2'd0;
    else if (lu)        e_cause = 2'd1;
    else if (raw || waw) e_cause = 2'd2;
    else if (full)      e_cause = 2'd3;
    else                e_cause = 2'd0;
    e_stall = (e_cause != 2'd0);
    e_issue = id_valid && id_long_op && !flush && !e_stall;
  endfunction

  task automatic tick();
    bit placed;
    model_eval();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NS; i++) done_t[i] = 0;
      m_perf = 0;
    end else begin
      placed = 0;
      if (e_issue)
        for (int i = 0; i < NS; i++)
          if (!placed && now >= done_t[i]) begin
            done_t[i] = now + ((id_lat == 0) ? 1 : int'(id_lat)) + 1;
            m_rd[i]   = id_rd;
            m_fp[i]   = id_rd_fp;
            placed    = 1;
          end
      if (e_stall && m_perf < PMAX) m_perf++;
    end
    now++;
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_long_op = 0; id_lat = '0; flush = 0;
    id_rs1 = '0; id_rs2 = '0; id_rs3 = '0; id_rd = '0; id_rd_fp = 0;
    id_rs1_en = 0; id_rs2_en = 0; id_rs3_en = 0;
    id_rs1_fp = 0; id_rs2_fp = 0; id_rs3_fp = 0;
    ex_mem_read = 0; ex_rd = '0; ex_rd_fp = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic long_op(input int rd, input bit fp, input int lat);
    idle();
    id_valid = 1; id_long_op = 1;
    id_rd = AW'(rd); id_rd_fp = fp; id_lat = LW'(lat);
  endtask

  task automatic test_reset();
    #1;
    vectors += 4;
    if (stall !== 1'b0) begin
      $display("FAIL rst_stall: got %0b want 0", stall); errs++; end
    if (stall_cause !== 2'd0) begin
      $display("FAIL rst_cause: got %0d want 0", stall_cause); errs++; end
    if (sb_busy !== '0) begin
      $display("FAIL rst_busy: got %b want 0000", sb_busy); errs++; end
    if (stall_cycles !== '0) begin
      $display("FAIL rst_perf: got %0d want 0", stall_cycles); errs++; end
    tick();
    rst = 0;
  endtask

  task automatic test_load_use();
    logic [1:0] want_c [7] = '{2'd1, 0, 0, 2'd1, 0, 0, 0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      idle();
      id_valid = 1; ex_mem_read = 1;
      unique case (k)
        0: begin ex_rd = 5; id_rs1 = 5; id_rs1_en = 1; end
        1: begin ex_mem_read = 0; ex_rd = 5; id_rs1 = 5; id_rs1_en = 1; end
        2: begin ex_rd = 0; id_rs1 = 0; id_rs1_en = 1; end
        3: begin ex_rd = 0; ex_rd_fp = 1; id_rs2 = 0;
                 id_rs2_en = 1; id_rs2_fp = 1; end
        4: begin ex_rd = 0; ex_rd_fp = 1; id_rs2 = 0; id_rs2_en = 1; end
        5: begin ex_rd = 3; ex_rd_fp = 1; id_rs3 = 3; id_rs3_en = 1; end
        default: begin ex_rd = 3; ex_rd_fp = 1; id_rs2 = 3;
                       id_rs2_fp = 1; end
      endcase
      #1;
      vectors += 2;
      if (stall !== (want_c[k] != 0)) begin
        $display("FAIL lu_stall[%0d]: got %0b want %0b",
                 k, stall, want_c[k] != 0); errs++; end
      if (stall_cause !== want_c[k]) begin
        $display("FAIL lu_cause[%0d]: got %0d want %0d",
                 k, stall_cause, want_c[k]); errs++; end
      tick();
    end
  endtask

  task automatic test_raw();
    do_reset();
    long_op(4, 1, 3);
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      $display("FAIL raw_issue: stall got %0b want 0", stall); errs++; end
    tick();
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k < 3) begin
        id_valid = 1; id_rs1 = 4; id_rs1_fp = 1; id_rs1_en = 1; id_rd = 9;
      end
      #1;
      vectors += 3;
      if (stall !== (k < 2)) begin
        $display("FAIL raw_stall[%0d]: got %0b want %0b", k, stall, k < 2);
        errs++; end
      if (stall_cause !== ((k < 2) ? 2'd2 : 2'd0)) begin
        $display("FAIL raw_cause[%0d]: got %0d", k, stall_cause); errs++; end
      if (sb_busy !== ((k < 3) ? 4'b0001 : 4'b0000)) begin
        $display("FAIL raw_busy[%0d]: got %b", k, sb_busy); errs++; end
      tick();
    end
  endtask

  task automatic test_full();
    int  n = 0;
    bit  rel = 0;
    do_reset();
    for (int j = 0; j < NS; j++) begin
      long_op(j + 1, 0, 20);
      #1;
      vectors++;
      if (stall !== 1'b0) begin
        $display("FAIL full_fill[%0d]: stall got %0b want 0", j, stall);
        errs++; end
      tick();
    end
    long_op(10, 0, 5);
    #1;
    vectors++;
    if (sb_busy !== 4'b1111) begin
      $display("FAIL full_busy: got %b want 1111", sb_busy); errs++; end
    while (!rel && n < 40) begin
      if (stall) begin
        vectors++;
        if (stall_cause !== 2'd3) begin
          $display("FAIL full_cause[%0d]: got %0d want 3", n, stall_cause);
          errs++; end
        n++;
        tick();
        #1;
      end else rel = 1;
    end
    vectors += 2;
    if (!rel) begin
      $display("FAIL full_timeout: stall held %0d cycles", n); errs++; end
    if (n != 17) begin
      $display("FAIL full_len: got %0d stall cycles want 17", n); errs++; end
    tick();
    idle();
    #1;
    vectors++;
    if (sb_busy !== 4'b1101) begin
      $display("FAIL full_reuse: got %b want 1101", sb_busy); errs++; end
    tick();
  endtask

  task automatic test_waw_flush();
    do_reset();
    long_op(7, 1, 10);
    tick();
    long_op(7, 1, 5);
    #1;
    vectors += 2;
    if (stall !== 1'b1) begin
      $display("FAIL waw_stall: got %0b want 1", stall); errs++; end
    if (stall_cause !== 2'd2) begin
      $display("FAIL waw_cause: got %0d want 2", stall_cause); errs++; end
    tick();
    long_op(7, 1, 5);
    flush = 1;
    #1;
    vectors += 2;
    if (stall !== 1'b0) begin
      $display("FAIL flush_stall: got %0b want 0", stall); errs++; end
    if (stall_cause !== 2'd0) begin
      $display("FAIL flush_cause: got %0d want 0", stall_cause); errs++; end
    tick();
    long_op(0, 0, 10);
    tick();
    long_op(0, 0, 3);
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      $display("FAIL waw_x0: stall got %0b want 0", stall); errs++; end
    tick();
    idle();
    #1;
    vectors++;
    if (sb_busy !== 4'b0111) begin
      $display("FAIL flush_busy: got %b want 0111", sb_busy); errs++; end
    tick();
  endtask

  task automatic test_rst_mid();
    do_reset();
    long_op(2, 1, 20);
    tick();
    idle();
    id_valid = 1; id_rs1 = 2; id_rs1_fp = 1; id_rs1_en = 1;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      $display("FAIL rmid_pre: stall got %0b want 1", stall); errs++; end
    #2 rst = 1;
    #1;
    vectors += 2;
    if (sb_busy !== '0) begin
      $display("FAIL rmid_busy: got %b want 0000", sb_busy); errs++; end
    if (stall !== 1'b0) begin
      $display("FAIL rmid_stall: got %0b want 0", stall); errs++; end
    tick();
    rst = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    id_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_en = 1;
    for (int k = 0; k < 70; k++) begin
      #1;
      vectors++;
      if (stall_cycles !== PW'((k < PMAX) ? k : PMAX)) begin
        $display("FAIL sat[%0d]: got %0d want %0d", k, stall_cycles,
                 (k < PMAX) ? k : PMAX); errs++; end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      id_valid    = ($urandom_range(0, 7) != 0);
      id_rs1      = AW'($urandom_range(0, 3));
      id_rs2      = AW'($urandom_range(0, 3));
      id_rs3      = AW'($urandom_range(0, 3));
      id_rs1_en   = 1'($urandom);
      id_rs2_en   = 1'($urandom);
      id_rs3_en   = ($urandom_range(0, 3) == 0);
      id_rs1_fp   = 1'($urandom);
      id_rs2_fp   = 1'($urandom);
      id_rs3_fp   = 1'($urandom);
      id_rd       = AW'($urandom_range(0, 3));
      id_rd_fp    = 1'($urandom);
      id_long_op  = ($urandom_range(0, 2) == 0);
      id_lat      = LW'($urandom_range(0, 7));
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_rd       = AW'($urandom_range(0, 3));
      ex_rd_fp    = 1'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      #1;
      model_eval();
      vectors += 4;
      if (stall !== e_stall) begin
        $display("FAIL rnd_stall[%0d]: got %0b want %0b", k, stall, e_stall);
        errs++; end
      if (stall_cause !== e_cause) begin
        $display("FAIL rnd_cause[%0d]: got %0d want %0d",
                 k, stall_cause, e_cause); errs++; end
      if (sb_busy !== e_busy) begin
        $display("FAIL rnd_busy[%0d]: got %b want %b", k, sb_busy, e_busy);
        errs++; end
      if (stall_cycles !== PW'(m_perf)) begin
        $display("FAIL rnd_perf[%0d]: got %0d want %0d",
                 k, stall_cycles, m_perf); errs++; end
      tick();
    end
  endtask

  initial begin
    now = 0; m_perf = 0;
    for (int i = 0; i < NS; i++) begin
      done_t[i] = 0; m_rd[i] = '0; m_fp[i] = 0;
    end
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_raw();
    test_full();
    test_waw_flush();
    test_rst_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
